// File: rtl/pulse_event_pkg.sv
// Shared types for the pulse event scheduler: detector modes and the
// output register state.
package pulse_event_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_RISE  = 2'd1,
      MODE_FALL  = 2'd2,
      MODE_PULSE = 2'd3
   } mode_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/pulse_event_scheduler_classifier.sv
// Per-channel detector: two-deep history of the input line, the channel's
// mode register and the rise/fall/pulse detect logic. A config write resets
// the history so that samples taken under the old mode cannot fire.
module pulse_classifier
   import pulse_event_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       a,
   input  logic       cfg_sel,
   input  logic [1:0] cfg_mode,
   output logic       det,
   output logic [1:0] mode
);

   logic  h1;
   logic  h2;
   mode_t mode_q;

   // History shift and mode register; a config write clears the history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h1     <= 1'b0;
         h2     <= 1'b0;
         mode_q <= MODE_OFF;
      end else if (cfg_sel) begin
         h1     <= 1'b0;
         h2     <= 1'b0;
         mode_q <= mode_t'(cfg_mode);
      end else begin
         h1 <= a;
         h2 <= h1;
      end
   end

   // Detect under the current mode; nothing is detected in a reconfigure cycle.
   always_comb begin
      det = 1'b0;
      unique case (mode_q)
         MODE_RISE:  det = ~h1 & a;
         MODE_FALL:  det = h1 & ~a;
         MODE_PULSE: det = ~h2 & h1 & ~a;
         default:    det = 1'b0;
      endcase
      if (cfg_sel) det = 1'b0;
   end

   assign mode = mode_q;

endmodule

// File: rtl/pulse_event_scheduler.sv
// Multi-channel edge/pulse event scheduler. Detected events are latched as
// pending per channel and served one at a time through a registered output
// port, with round-robin arbitration starting after the last granted channel.
//
// Handshake: out_valid/out_chan/out_mode are registered. An event transfers
// on a rising clk edge where out_valid & out_ready are both 1. While
// out_valid=1 and out_ready=0 the output fields hold steady. out_valid never
// depends combinationally on out_ready.
module pulse_event_scheduler
   import pulse_event_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int CW   = $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] a,
   input  logic            cfg_we,
   input  logic [CW-1:0]   cfg_chan,
   input  logic [1:0]      cfg_mode,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [CW-1:0]   out_chan,
   output logic [1:0]      out_mode,
   output logic [N_CH-1:0] ovf,
   input  logic            ovf_clr,
   output logic            dbg_state
);

   logic [N_CH-1:0]      det;
   logic [N_CH-1:0]      cfg_sel;
   logic [N_CH-1:0]      pend;
   logic [N_CH-1:0]      elig;
   logic [N_CH-1:0]      grant_oh;
   logic [N_CH-1:0][1:0] ch_mode;
   logic [CW-1:0]        last;
   logic [CW-1:0]        grant_idx;
   logic                 grant_found;
   logic                 load;
   out_state_t           state;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      // Out-of-range channel numbers match no channel and are dropped here.
      assign cfg_sel[g] = cfg_we && (cfg_chan == CW'(g));

      pulse_classifier u_cls (
         .clk      (clk),
         .rst      (rst),
         .a        (a[g]),
         .cfg_sel  (cfg_sel[g]),
         .cfg_mode (cfg_mode),
         .det      (det[g]),
         .mode     (ch_mode[g])
      );
   end

   // A channel being reconfigured this cycle loses its pending event, so it
   // must not be granted in that same cycle either.
   assign elig = pend & ~cfg_sel;

   // Round-robin search: first eligible channel after last, wrapping.
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 1; i <= N_CH; i++) begin
         idx = (int'(last) + i) % N_CH;
         if (!grant_found && elig[idx]) begin
            grant_found = 1'b1;
            grant_idx   = CW'(idx);
         end
      end
   end

   assign load     = grant_found && ((state == ST_EMPTY) || out_ready);
   assign grant_oh = load ? ({{(N_CH-1){1'b0}}, 1'b1} << grant_idx) : '0;

   // Pending flags: a detection wins over a same-cycle grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend <= '0;
      else     pend <= (pend & ~grant_oh & ~cfg_sel) | det;
   end

   // Sticky overflow: detection on an already-pending, ungranted channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf <= '0;
      else     ovf <= (ovf & {N_CH{~ovf_clr}}) | (det & pend & ~grant_oh);
   end

   // Output register FSM: load on grant, drain to EMPTY on an unrefilled accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_EMPTY;
         out_chan <= '0;
         out_mode <= 2'd0;
         last     <= CW'(N_CH - 1);
      end else if (load) begin
         state    <= ST_FULL;
         out_chan <= grant_idx;
         out_mode <= ch_mode[grant_idx];
         last     <= grant_idx;
      end else if ((state == ST_FULL) && out_ready) begin
         state <= ST_EMPTY;
      end
   end

   assign out_valid = (state == ST_FULL);
   assign dbg_state = state;

endmodule
